// File: rtl/keycode_stream_pio_pkg.sv
// Shared register map for the keycode stream port: addresses and bit positions
// of the STATUS and CTRL registers.
package keycode_stream_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_LEVEL_LSB = 8;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

endpackage

// File: rtl/keycode_stream_pio_if.sv
// Avalon-MM slave bus plus the outgoing keycode stream of keycode_stream_pio.
// The slave modport is the port block; master is the fabric/consumer side.
interface keycode_stream_pio_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_port;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_data, out_valid, out_port
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_data, out_valid, out_port
    );
endinterface

// File: rtl/keycode_stream_pio_fifo.sv
// Synchronous keycode FIFO with level counter and flush; head is shown on dout
// combinationally and reads zero while empty.
module keycode_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keycode_stream_pio.sv
// Avalon-MM keycode port: software-written keycodes are queued and streamed to
// the voice logic, with status, control, sticky overflow and interrupt.
module keycode_stream_pio
    import keycode_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    keycode_stream_pio_if.slave   bus,
    output logic                  irq
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              wr_strobe;
    logic              wr_data;
    logic              wr_status;
    logic              wr_ctrl;
    logic              flush;
    logic              pop;
    logic              ovf_set;
    logic              ovf_clr;

    logic              enable;
    logic              irq_en;
    logic              overflow;
    logic              enable_nxt;
    logic              irq_en_nxt;
    logic              overflow_nxt;
    logic [DATA_W-1:0] out_port_q;

    logic [DATA_W-1:0] fifo_dout;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;

    logic              unused_wdata;

    assign wr_strobe = bus.chipselect & ~bus.write_n;
    assign wr_data   = wr_strobe & (bus.address == ADDR_DATA);
    assign wr_status = wr_strobe & (bus.address == ADDR_STATUS);
    assign wr_ctrl   = wr_strobe & (bus.address == ADDR_CTRL);

    assign flush = wr_ctrl & bus.writedata[CTRL_FLUSH_BIT];

    // A flush beats a simultaneous accept, so out_port keeps its value.
    assign pop = bus.out_valid & bus.out_ready & ~flush;

    assign ovf_set = wr_data & fifo_full & ~pop;
    assign ovf_clr = wr_status & bus.writedata[STATUS_OVF_BIT];

    assign unused_wdata = ^bus.writedata;

    keycode_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .din   (bus.writedata[DATA_W-1:0]),
        .pop   (pop),
        .flush (flush),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_valid = enable & ~fifo_empty;
    assign bus.out_data  = fifo_dout;
    assign bus.out_port  = out_port_q;

    always_comb begin
        enable_nxt   = enable;
        irq_en_nxt   = irq_en;
        overflow_nxt = overflow;
        if (wr_ctrl) begin
            enable_nxt = bus.writedata[CTRL_ENABLE_BIT];
            irq_en_nxt = bus.writedata[CTRL_IRQ_EN_BIT];
        end
        if (ovf_clr) overflow_nxt = 1'b0;
        if (ovf_set) overflow_nxt = 1'b1;
    end

    // irq is built from the next-state values so it moves with overflow/irq_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable     <= 1'b1;
            irq_en     <= 1'b0;
            overflow   <= 1'b0;
            irq        <= 1'b0;
            out_port_q <= '0;
        end else begin
            enable   <= enable_nxt;
            irq_en   <= irq_en_nxt;
            overflow <= overflow_nxt;
            irq      <= irq_en_nxt & overflow_nxt;
            if (pop) out_port_q <= fifo_dout;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA: begin
                bus.readdata[DATA_W-1:0] = out_port_q;
            end
            ADDR_STATUS: begin
                bus.readdata[STATUS_EMPTY_BIT] = fifo_empty;
                bus.readdata[STATUS_FULL_BIT]  = fifo_full;
                bus.readdata[STATUS_OVF_BIT]   = overflow;
                bus.readdata[STATUS_LEVEL_LSB +: LVL_W] = fifo_level;
            end
            ADDR_CTRL: begin
                bus.readdata[CTRL_ENABLE_BIT] = enable;
                bus.readdata[CTRL_IRQ_EN_BIT] = irq_en;
            end
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_keycode_stream_pio.sv
// Self-checking bench for keycode_stream_pio: directed test-plan steps followed
// by a randomized phase, all checked against a queue-based reference model.
module tb_keycode_stream_pio;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;
    logic irq;

    keycode_stream_pio_if #(.DATA_W(DW)) bus ();

    keycode_stream_pio #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: the FIFO is a plain queue of keycodes.
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_en;
    logic          m_irq_en;
    logic [DW-1:0] m_port;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            2'd0: r = {24'h0, m_port};
            2'd1: r = (32'(q.size()) << 8) | (m_ovf ? 32'h4 : 32'h0)
                      | ((q.size() == DEPTH) ? 32'h2 : 32'h0)
                      | ((q.size() == 0) ? 32'h1 : 32'h0);
            2'd2: r = {29'h0, m_irq_en, 1'b0, m_en};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_en     = 1'b1;
        m_irq_en = 1'b0;
        m_port   = '0;
    endfunction

    task automatic drive(input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] wd, input logic rdy);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        bus.out_ready  = rdy;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":valid"}, 32'(bus.out_valid), 32'(m_en && q.size() > 0));
        if (m_en && q.size() > 0)
            chk({tag, ":data"}, 32'(bus.out_data), 32'(q[0]));
        chk({tag, ":port"}, 32'(bus.out_port), 32'(m_port));
        chk({tag, ":irq"}, 32'(irq), 32'(m_irq_en & m_ovf));
    endtask

    // One clock: check readdata before the edge, advance the model, check outputs.
    task automatic step(input string tag);
        logic          wr;
        logic          fl;
        logic          pop;
        logic          set;
        logic [1:0]    a;
        logic [31:0]   wd;
        #1;
        chk({tag, ":rd"}, bus.readdata, exp_rd(bus.address));
        a   = bus.address;
        wd  = bus.writedata;
        wr  = bus.chipselect & ~bus.write_n;
        fl  = wr && a == 2'd2 && wd[1];
        pop = m_en && q.size() > 0 && bus.out_ready && !fl;
        set = 1'b0;
        if (pop) m_port = q.pop_front();
        if (wr && a == 2'd0) begin
            if (q.size() < DEPTH) q.push_back(wd[DW-1:0]);
            else set = 1'b1;
        end
        if (wr && a == 2'd1 && wd[2]) m_ovf = 1'b0;
        if (set) m_ovf = 1'b1;
        if (wr && a == 2'd2) begin
            m_en     = wd[0];
            m_irq_en = wd[2];
            if (wd[1]) q.delete();
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic wr(input string tag, input logic [1:0] a, input logic [31:0] wd,
                      input logic rdy);
        drive(1'b1, 1'b0, a, wd, rdy);
        step(tag);
    endtask

    task automatic idle(input string tag, input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 2'd0, 32'h0, rdy);
            step(tag);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b1, a, 32'h0, bus.out_ready);
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    initial begin
        logic [31:0] v;
        int          r;
        vectors     = 0;
        miscompares = 0;
        model_reset();
        drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        reset = 1'b1;
        #23;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data", 32'(bus.out_data), 32'h0);
        chk("rst_port", 32'(bus.out_port), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd_chk("rst_status", 2'd1, 32'h0000_0001);
        rd_chk("rst_ctrl", 2'd2, 32'h0000_0001);
        rd_chk("rst_addr3", 2'd3, 32'h0);

        // Three keycodes, then drain them back to back
        wr("w3c", 2'd0, 32'h3C, 1'b0);
        wr("w40", 2'd0, 32'h40, 1'b0);
        wr("w43", 2'd0, 32'h43, 1'b0);
        rd_chk("lvl3", 2'd1, 32'h0000_0300);
        chk("head3c", 32'(bus.out_data), 32'h3C);
        idle("drain3", 1'b1, 3);
        chk("port43", 32'(bus.out_port), 32'h43);
        rd_chk("empty3", 2'd1, 32'h0000_0001);

        // Overflow: 17 writes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) begin
            v = $urandom;
            wr("fill", 2'd0, v, 1'b0);
        end
        rd_chk("full_ovf", 2'd1, 32'h0000_1006);
        wr("irq_en", 2'd2, 32'h5, 1'b0);
        chk("irq_on", 32'(irq), 32'h1);
        wr("ovf_clr", 2'd1, 32'h4, 1'b0);
        chk("irq_off", 32'(irq), 32'h0);
        rd_chk("ovf_cleared", 2'd1, 32'h0000_1002);

        // Push while full with a simultaneous pop
        wr("full_pop_push", 2'd0, 32'h7F, 1'b1);
        rd_chk("lvl16_noovf", 2'd1, 32'h0000_1002);
        idle("drain16", 1'b1, 16);
        chk("last7f", 32'(bus.out_port), 32'h7F);

        // Flush beats a same-cycle accept
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            wr("load5", 2'd0, v, 1'b0);
        end
        wr("flush", 2'd2, 32'h3, 1'b1);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_port", 32'(bus.out_port), 32'h7F);
        rd_chk("flush_status", 2'd1, 32'h0000_0001);

        // Disable holds the queue; re-enable drains in order
        wr("w11", 2'd0, 32'h11, 1'b0);
        wr("w22", 2'd0, 32'h22, 1'b0);
        wr("disable", 2'd2, 32'h0, 1'b0);
        idle("held", 1'b1, 3);
        chk("held_port", 32'(bus.out_port), 32'h7F);
        wr("enable", 2'd2, 32'h1, 1'b1);
        idle("drain2", 1'b1, 2);
        chk("port22", 32'(bus.out_port), 32'h22);

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b1;
                #1;
                model_reset();
                chk("arst_valid", 32'(bus.out_valid), 32'h0);
                chk("arst_port", 32'(bus.out_port), 32'h0);
                chk("arst_irq", 32'(irq), 32'h0);
                #1;
                reset = 1'b0;
            end
            r = $urandom_range(0, 9);
            v = $urandom;
            if (r <= 4) begin
                drive(1'b1, 1'b0, 2'd0, v, ($urandom_range(0, 9) < 4));
            end else if (r == 5) begin
                drive(1'b1, 1'b0, 2'd1, v, ($urandom_range(0, 9) < 4));
            end else if (r == 6) begin
                v[0] = ($urandom_range(0, 3) != 0);
                v[1] = ($urandom_range(0, 3) == 0);
                drive(1'b1, 1'b0, 2'd2, v, ($urandom_range(0, 9) < 4));
            end else if (r == 7) begin
                drive(1'b1, 1'b0, 2'd3, v, ($urandom_range(0, 9) < 4));
            end else begin
                drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), v, ($urandom_range(0, 9) < 4));
            end
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
